instr_fetch_unit: RTL and testbench

- Reader side of the 8-bit program memory. Drives the byte address, captures one instruction byte per clock, and assembles variable-length instructions (opcode plus 0–2 operand bytes).
- Presents each complete instruction to the execute stage over a valid/ready handshake.
- Accepts PC redirects (jumps) from execute.
- Sits between the program memory, which has a combinational read, and the datapath controller.

---
 rtl/instr_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : Program-memory reader. Drives the byte address, assembles
//               variable-length instructions (opcode + 0..2 operands) and
//               hands them to execute over a valid/ready handshake. Accepts
//               PC redirects from execute.
//               Optional: define IFU_JMP_FOLD_EN to resolve JMP (8'h07)
//               inside the fetch unit instead of presenting it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] pm_addr,
  input  logic [7:0] pm_data,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] instr_opcode,
  output logic [7:0] instr_op1,
  output logic [7:0] instr_op2,
  output logic [1:0] instr_len,
  output logic [7:0] instr_pc,
  output logic       instr_illegal,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_addr
);

  typedef enum logic [1:0] {
    FETCH_OP = 2'd0,
    FETCH_B1 = 2'd1,
    FETCH_B2 = 2'd2,
    HOLD     = 2'd3
  } state_t;

  localparam logic [7:0] c_OP_JMP = 8'h07;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_pc;
  logic [7:0] r_opcode;
  logic [7:0] r_op1;
  logic [7:0] r_op2;
  logic [1:0] r_len;
  logic [7:0] r_ipc;
  logic       r_illegal;
  logic [1:0] w_dec_len;
  logic       w_dec_illegal;
  logic       w_fold_jmp;

  // Length/legality decode of the byte currently on the memory bus
  always_comb begin
    w_dec_len     = 2'd1;
    w_dec_illegal = 1'b0;
    case (pm_data)
      8'h00:   w_dec_len = 2'd3;
      8'h01:   w_dec_len = 2'd2;
      8'h03:   w_dec_len = 2'd2;
      8'h06:   w_dec_len = 2'd3;
      8'h07:   w_dec_len = 2'd2;
      8'h12:   w_dec_len = 2'd1;
      default: w_dec_illegal = 1'b1;
    endcase
  end

`ifdef IFU_JMP_FOLD_EN
  // JMP target byte is on the bus during FETCH_B1; take it as the new PC
  assign w_fold_jmp = (r_state == FETCH_B1) && (r_opcode == c_OP_JMP);
`else
  assign w_fold_jmp = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FETCH_OP;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; an external redirect overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    if (redirect_valid) begin
      w_state_nxt = FETCH_OP;
    end else begin
      case (r_state)
        FETCH_OP: w_state_nxt = (w_dec_len == 2'd1) ? HOLD : FETCH_B1;
        FETCH_B1: begin
          if (w_fold_jmp)            w_state_nxt = FETCH_OP;
          else if (r_len == 2'd2)    w_state_nxt = HOLD;
          else                       w_state_nxt = FETCH_B2;
        end
        FETCH_B2: w_state_nxt = HOLD;
        HOLD:     if (instr_ready) w_state_nxt = FETCH_OP;
        default:  w_state_nxt = FETCH_OP;
      endcase
    end
  end

  // PC and instruction assembly registers; fields stay frozen during HOLD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_opcode  <= 8'h00;
      r_op1     <= 8'h00;
      r_op2     <= 8'h00;
      r_len     <= 2'd0;
      r_ipc     <= 8'h00;
      r_illegal <= 1'b0;
    end else if (redirect_valid) begin
      r_pc <= redirect_addr;
    end else begin
      case (r_state)
        FETCH_OP: begin
          r_opcode  <= pm_data;
          r_ipc     <= r_pc;
          r_op1     <= 8'h00;
          r_op2     <= 8'h00;
          r_len     <= w_dec_len;
          r_illegal <= w_dec_illegal;
          r_pc      <= r_pc + 8'd1;
        end
        FETCH_B1: begin
          r_op1 <= pm_data;
          r_pc  <= w_fold_jmp ? pm_data : (r_pc + 8'd1);
        end
        FETCH_B2: begin
          r_op2 <= pm_data;
          r_pc  <= r_pc + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign pm_addr       = r_pc;
  assign instr_valid   = (r_state == HOLD);
  assign instr_opcode  = r_opcode;
  assign instr_op1     = r_op1;
  assign instr_op2     = r_op2;
  assign instr_len     = r_len;
  assign instr_pc      = r_ipc;
  assign instr_illegal = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none

module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  // instance 0: RESET_PC = 0
  logic [7:0] a0, d0, opc0, op1_0, op2_0, ipc0, rda0;
  logic [1:0] len0;
  logic       v0, rdy0, ill0, rdv0;
  // instance 1: RESET_PC = FE
  logic [7:0] a1, d1, opc1, op1_1, op2_1, ipc1;
  logic [1:0] len1;
  logic       v1, rdy1, ill1;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign d0 = mem0[a0];
  assign d1 = mem1[a1];

  instr_fetch_unit #(.RESET_PC(8'h00)) dut0 (
    .clk(clk), .rst(rst), .pm_addr(a0), .pm_data(d0),
    .instr_valid(v0), .instr_ready(rdy0), .instr_opcode(opc0),
    .instr_op1(op1_0), .instr_op2(op2_0), .instr_len(len0), .instr_pc(ipc0),
    .instr_illegal(ill0), .redirect_valid(rdv0), .redirect_addr(rda0)
  );

  instr_fetch_unit #(.RESET_PC(8'hFE)) dut1 (
    .clk(clk), .rst(rst), .pm_addr(a1), .pm_data(d1),
    .instr_valid(v1), .instr_ready(rdy1), .instr_opcode(opc1),
    .instr_op1(op1_1), .instr_op2(op2_1), .instr_len(len1), .instr_pc(ipc1),
    .instr_illegal(ill1), .redirect_valid(1'b0), .redirect_addr(8'h00)
  );

  typedef struct {
    logic [7:0] op;
    logic [7:0] e_opc;
    logic [7:0] e_op1;
    logic [7:0] e_op2;
    logic [1:0] e_len;
    logic       e_ill;
    logic [7:0] e_pc;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input bit sel, output int cyc);
    cyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((sel ? v1 : v0) === 1'b1) begin
        cyc = i;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL timeout waiting for instr_valid on dut%0d", sel);
  endtask

  task automatic chk0(input string tag, input logic [7:0] opc, input logic [7:0] o1,
                      input logic [7:0] o2, input logic [1:0] ln, input logic il,
                      input logic [7:0] pc);
    chk({tag, ".valid"},   v0,    1'b1);
    chk({tag, ".opcode"},  opc0,  opc);
    chk({tag, ".op1"},     op1_0, o1);
    chk({tag, ".op2"},     op2_0, o2);
    chk({tag, ".len"},     len0,  ln);
    chk({tag, ".illegal"}, ill0,  il);
    chk({tag, ".pc"},      ipc0,  pc);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    rdv0 = 1'b0;
    rda0 = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic accept0();
    rdy0 = 1'b1;
    @(posedge clk);
    #1 rdy0 = 1'b0;
  endtask

  int cyc;

  initial begin
    // name, opcode, exp opcode, op1, op2, len, illegal, instr_pc
    tbl[0] = '{8'h00, 8'h00, 8'h11, 8'h22, 2'd3, 1'b0, 8'h00};
    tbl[1] = '{8'h01, 8'h01, 8'h11, 8'h00, 2'd2, 1'b0, 8'h00};
    tbl[2] = '{8'h03, 8'h03, 8'h11, 8'h00, 2'd2, 1'b0, 8'h00};
    tbl[3] = '{8'h06, 8'h06, 8'h11, 8'h22, 2'd3, 1'b0, 8'h00};
`ifdef IFU_JMP_FOLD_EN
    tbl[4] = '{8'h07, 8'h12, 8'h00, 8'h00, 2'd1, 1'b0, 8'h11};
`else
    tbl[4] = '{8'h07, 8'h07, 8'h11, 8'h00, 2'd2, 1'b0, 8'h00};
`endif
    tbl[5] = '{8'h12, 8'h12, 8'h00, 8'h00, 2'd1, 1'b0, 8'h00};
    tbl[6] = '{8'hAB, 8'hAB, 8'h00, 8'h00, 2'd1, 1'b1, 8'h00};
    tbl[7] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 2'd1, 1'b1, 8'h00};

    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'h12;
      mem1[i] = 8'h12;
    end

    // Reset state, sampled while rst is held
    rst = 1'b1; rdy0 = 1'b0; rdy1 = 1'b0; rdv0 = 1'b0; rda0 = 8'h00;
    @(negedge clk);
    chk("rst.valid",   v0,    1'b0);
    chk("rst.addr",    a0,    8'h00);
    chk("rst.addr1",   a1,    8'hFE);
    chk("rst.opcode",  opc0,  8'h00);
    chk("rst.op1",     op1_0, 8'h00);
    chk("rst.op2",     op2_0, 8'h00);
    chk("rst.len",     len0,  2'd0);
    chk("rst.pc",      ipc0,  8'h00);
    chk("rst.illegal", ill0,  1'b0);

    // Decode table: opcode at 0, operands 11 22, filler CLR elsewhere
    for (int k = 0; k < 8; k++) begin
      mem0[0] = tbl[k].op;
      mem0[1] = 8'h11;
      mem0[2] = 8'h22;
      do_reset();
      wait_valid(1'b0, cyc);
      chk0($sformatf("tbl%0d", k), tbl[k].e_opc, tbl[k].e_op1, tbl[k].e_op2,
           tbl[k].e_len, tbl[k].e_ill, tbl[k].e_pc);
      accept0();
      @(negedge clk);
      chk($sformatf("tbl%0d.drop", k), v0, 1'b0);
      chk($sformatf("tbl%0d.next", k), a0, tbl[k].e_pc + {6'd0, tbl[k].e_len});
    end

    // JMP program 07 03 01 03 14
    mem0[0] = 8'h07; mem0[1] = 8'h03; mem0[2] = 8'h01; mem0[3] = 8'h03; mem0[4] = 8'h14;
    do_reset();
    wait_valid(1'b0, cyc);
`ifdef IFU_JMP_FOLD_EN
    chk("fold.cycle", cyc, 4);
    chk0("fold", 8'h03, 8'h14, 8'h00, 2'd2, 1'b0, 8'h03);
`else
    chk("jmp.cycle", cyc, 2);
    chk0("jmp", 8'h07, 8'h03, 8'h00, 2'd2, 1'b0, 8'h00);
    // accept and redirect in the same cycle: no replay
    rdy0 = 1'b1; rdv0 = 1'b1; rda0 = 8'h03;
    @(posedge clk);
    #1 rdy0 = 1'b0; rdv0 = 1'b0;
    @(negedge clk);
    chk("jmp.redir.valid", v0, 1'b0);
    chk("jmp.redir.addr",  a0, 8'h03);
    wait_valid(1'b0, cyc);
    chk0("jmp.tgt", 8'h03, 8'h14, 8'h00, 2'd2, 1'b0, 8'h03);
`endif

    // Held 3-byte MOV at 5, then CLR at 8
    mem0[5] = 8'h06; mem0[6] = 8'h07; mem0[7] = 8'h02; mem0[8] = 8'h12;
    do_reset();
    rdv0 = 1'b1; rda0 = 8'h05;
    @(posedge clk);
    #1 rdv0 = 1'b0;
    wait_valid(1'b0, cyc);
    chk0("hold0", 8'h06, 8'h07, 8'h02, 2'd3, 1'b0, 8'h05);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk0($sformatf("hold%0d", c), 8'h06, 8'h07, 8'h02, 2'd3, 1'b0, 8'h05);
    end
    accept0();
    @(negedge clk);
    chk("clr.gap", v0, 1'b0);
    @(negedge clk);
    chk0("clr", 8'h12, 8'h00, 8'h00, 2'd1, 1'b0, 8'h08);

    // Reset during HOLD acts immediately
    rst = 1'b1;
    #1;
    chk("midrst.valid", v0, 1'b0);
    chk("midrst.addr",  a0, 8'h00);
    chk("midrst.len",   len0, 2'd0);
    @(negedge clk);

    // Redirect during FETCH_B1 of a 3-byte instruction
    mem0[0] = 8'h00; mem0[1] = 8'h55; mem0[2] = 8'h66; mem0[8'h20] = 8'h12;
    do_reset();
    @(posedge clk);
    #1 rdv0 = 1'b1; rda0 = 8'h20;
    @(negedge clk);
    chk("rdb1.valid0", v0, 1'b0);
    @(posedge clk);
    #1 rdv0 = 1'b0;
    @(negedge clk);
    chk("rdb1.valid1", v0, 1'b0);
    chk("rdb1.addr",   a0, 8'h20);
    wait_valid(1'b0, cyc);
    chk0("rdb1.tgt", 8'h12, 8'h00, 8'h00, 2'd1, 1'b0, 8'h20);

    // PC wrap on instance with RESET_PC = FE
    mem1[8'hFE] = 8'h00; mem1[8'hFF] = 8'h05; mem1[8'h00] = 8'h02; mem1[8'h01] = 8'h12;
    do_reset();
    wait_valid(1'b1, cyc);
    chk("wrap.opcode", opc1,  8'h00);
    chk("wrap.op1",    op1_1, 8'h05);
    chk("wrap.op2",    op2_1, 8'h02);
    chk("wrap.len",    len1,  2'd3);
    chk("wrap.pc",     ipc1,  8'hFE);
    chk("wrap.ill",    ill1,  1'b0);
    rdy1 = 1'b1;
    @(posedge clk);
    #1 rdy1 = 1'b0;
    @(negedge clk);
    chk("wrap.drop", v1, 1'b0);
    chk("wrap.next", a1, 8'h01);
    wait_valid(1'b1, cyc);
    chk("wrap2.opcode", opc1, 8'h12);
    chk("wrap2.pc",     ipc1, 8'h01);
    chk("wrap2.len",    len1, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
